// File: rtl/instr_mem_ctrl_if.sv
// Load-port and fetch-port signal bundle for instr_mem_ctrl; IMEM_PARITY_EN adds load_par_flip/par_err.
interface instr_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              load_start;
  logic              run_start;
  logic              load_valid;
  logic              load_last;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              instr_stall;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic              addr_err;
  logic [1:0]        mem_state;
`ifdef IMEM_PARITY_EN
  logic              load_par_flip;
  logic              par_err;
`endif

  modport master (
`ifdef IMEM_PARITY_EN
    output load_par_flip,
    input  par_err,
`endif
    output load_start, run_start, load_valid, load_last, load_data,
    output fetch_req, fetch_addr, instr_stall,
    input  load_ready, load_done, fetch_ready, instr_valid, instr, addr_err, mem_state
  );

  modport slave (
`ifdef IMEM_PARITY_EN
    input  load_par_flip,
    output par_err,
`endif
    input  load_start, run_start, load_valid, load_last, load_data,
    input  fetch_req, fetch_addr, instr_stall,
    output load_ready, load_done, fetch_ready, instr_valid, instr, addr_err, mem_state
  );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory: word-serial load port, registered fetch with 1-cycle latency.
// A held word blocks new fetches while instr_stall is high; IMEM_PARITY_EN adds per-word even parity.
module instr_mem_ctrl #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 256,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic             clk,
  input logic             rst,
  instr_mem_ctrl_if.slave bus
);
  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic              r_load_done;
  logic              r_instr_valid;
  logic              r_addr_err;
  logic [DATA_W-1:0] r_instr;
  logic              w_load_rdy;
  logic              w_fetch_rdy;
  logic              w_wr;
  logic              w_last_wr;
  logic              w_fetch_acc;
  logic              w_err;
  logic [PTR_W-1:0]  w_ridx;
  logic [MEM_W-1:0]  w_rword;
  logic [MEM_W-1:0]  w_wword;
`ifdef IMEM_PARITY_EN
  logic              r_par_err;
`endif

  // load_start always wins over a word presented in the same cycle
  assign w_wr      = (r_state == S_LOAD) && bus.load_valid && !bus.load_start;
  assign w_last_wr = w_wr && (bus.load_last || (r_ptr == PTR_W'(DEPTH - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_rdy  = 1'b0;
    w_fetch_rdy = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_start)     w_state_nxt = S_LOAD;
        else if (bus.run_start) w_state_nxt = S_RUN;
      end
      S_LOAD: begin
        w_load_rdy = 1'b1;
        if (w_last_wr) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_fetch_rdy = !(r_instr_valid && bus.instr_stall);
        if (bus.load_start) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_ptr <= '0;
    else if (bus.load_start)                    r_ptr <= '0;
    else if (w_wr && r_ptr != PTR_W'(DEPTH-1))  r_ptr <= r_ptr + PTR_W'(1);
  end

`ifdef IMEM_PARITY_EN
  assign w_wword = {(^bus.load_data) ^ bus.load_par_flip, bus.load_data};
`else
  assign w_wword = bus.load_data;
`endif

  // Array has no reset so a program survives rst; state is IDLE under reset, so no stray write
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_ptr] <= w_wword;
  end

  assign w_ridx      = bus.fetch_addr[PTR_W+1:2];
  assign w_rword     = r_mem[w_ridx];
  assign w_err       = (bus.fetch_addr[1:0] != 2'b00) || ((bus.fetch_addr >> 2) >= DEPTH_A);
  assign w_fetch_acc = bus.fetch_req && w_fetch_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_done   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
      r_instr       <= '0;
`ifdef IMEM_PARITY_EN
      r_par_err     <= 1'b0;
`endif
    end else begin
      r_load_done <= (r_state == S_LOAD) && (w_state_nxt == S_RUN);
      if (r_state != S_RUN || bus.load_start) begin
        r_instr_valid <= 1'b0;
      end else if (w_fetch_acc) begin
        r_instr_valid <= 1'b1;
        r_addr_err    <= w_err;
        r_instr       <= w_err ? NOP_WORD : w_rword[DATA_W-1:0];
`ifdef IMEM_PARITY_EN
        r_par_err     <= !w_err && ((^w_rword[DATA_W-1:0]) != w_rword[DATA_W]);
`endif
      end else if (!(r_instr_valid && bus.instr_stall)) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign bus.load_ready  = w_load_rdy;
  assign bus.load_done   = r_load_done;
  assign bus.fetch_ready = w_fetch_rdy;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.addr_err    = r_addr_err;
  assign bus.mem_state   = r_state;
`ifdef IMEM_PARITY_EN
  assign bus.par_err     = r_par_err;
`endif
endmodule
